fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset. The ports SHALL be clock_i (input, 1, rising-edge clock) and rst_n_i (input, 1, synchronous active-low reset).
REQ-002 Parameter RESET_PC SHALL default to 32'h0000_0000 and give the first fetch PC after reset.
REQ-003 The data ports SHALL be:
- redirect_i  input  1  backend branch/jump redirect request.
- redirect_pc_i  input  32  redirect target.
- halt_i  input  1  stop issuing new fetches.
- addr_o  output  10  instruction memory doubleword address.
- data_i  input  64  imem read data, valid one cycle after addr_o.
- valid_o  output  1  instruction pair available.
- ready_i  input  1  downstream accepts the pair.
- pc_o  output  32  PC of inst_0_o.
- inst_0_o  output  32  first instruction in program order.
- inst_1_o  output  32  second instruction.
- slot_vld_o  output  2  per-slot valid mask, bit0 = inst_0.

Function
REQ-004 Fetch PC low bits [1:0] SHALL be forced to zero, and addr_o SHALL equal fetch PC[12:3], wrapping modulo 1024.
REQ-005 When fetch PC[2]=0, the pair SHALL be inst_0=data_i[31:0] and inst_1=data_i[63:32], with slot_vld=2'b11.
REQ-006 When fetch PC[2]=1, inst_0 SHALL be data_i[63:32] and inst_1 SHALL be 32'h0000_0013 (NOP), with slot_vld=2'b01.
REQ-007 Sequential next PC SHALL be (PC & ~32'h7) + 8, with 32-bit wrap at 2^32.
REQ-008 Memory latency SHALL be fixed at 1 cycle: the address on addr_o in cycle T yields data_i sampled at the end of cycle T+1.
REQ-009 Returned pairs SHALL enter a 2-entry FIFO that drives valid_o, pc_o, inst_*_o and slot_vld_o from its head register, with no combinational path from data_i.
REQ-010 A new fetch SHALL issue in a cycle only if (FIFO occupancy + in-flight reads) < 2, halt_i=0 and the state is RUN. Otherwise addr_o SHALL hold its value and the PC SHALL NOT advance.
REQ-011 A transfer SHALL occur when valid_o && ready_i. The FIFO SHALL pop on transfer, push on a valid return, and support push and pop in the same cycle at any occupancy.
REQ-012 valid_o SHALL never deassert without a transfer except on redirect or reset.
REQ-013 The state machine SHALL have two states:
- BOOT: the single cycle after reset; issues RESET_PC; goes to RUN.
- RUN: normal operation.
REQ-014 Redirect SHALL take priority over every other event. On redirect_i=1 in cycle N:
- the FIFO SHALL be flushed (valid_o=0 in N+1);
- the in-flight read SHALL be killed and its data discarded at N+1;
- addr_o SHALL equal redirect_pc_i[12:3] in N+1;
- the first valid_o for the target SHALL occur in N+3.
REQ-015 A redirect coinciding with a transfer SHALL complete the transfer in cycle N and then flush.
REQ-016 Back-to-back redirects SHALL make only the last target effective.
REQ-017 While halt_i=1, in-flight data SHALL still be captured and the FIFO SHALL drain normally. Fetching SHALL resume from the held PC the cycle after halt_i falls.
REQ-018 Steady-state throughput with ready_i=1 SHALL be one pair per cycle.

Reset
REQ-019 While rst_n_i=0 at a rising edge, the outputs and state SHALL take these values:
- valid_o=0, slot_vld_o=2'b00, pc_o=0, inst_0_o=inst_1_o=0;
- FIFO empty, in-flight cleared, state=BOOT;
- fetch PC=RESET_PC, addr_o=RESET_PC[12:3].
REQ-020 Reset asserted mid-operation SHALL discard all buffered and in-flight data, and no stale pair SHALL appear after reset releases.
REQ-021 The first valid_o after reset release SHALL occur no earlier than the 3rd cycle after release.

Structure
REQ-022 A shared core_pkg SHALL hold:
- IMEM_AW=10;
- NOP_INST=32'h0000_0013;
- the fetch-entry typedef {pc[31:0], inst0[31:0], inst1[31:0], vld[1:0]}.
REQ-023 The FIFO SHALL be a sub-module fetch_buf: 2-entry, push/pop/flush, count output.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset with RESET_PC=0 and ready_i=1 held -> pairs with pc_o=0x0, 0x8, 0x10… on consecutive cycles, slot_vld=11.
- Redirect to 0x0000_0104 -> addr_o=0x020 the next cycle; pair pc_o=0x104, inst_0=upper word, inst_1=0x13, slot_vld=01; next pc_o=0x108.
- ready_i=0 for 5 cycles while streaming -> FIFO fills to 2, addr_o stable, no pair lost or duplicated after ready_i returns.
- Redirect in the same cycle as a transfer and a data return -> exactly one transfer, the stale return dropped, valid_o=0 for 2 cycles.
- Fetch from 0x0000_1FF8 -> next addr_o wraps 0x3FF→0x000 while pc_o=0x2000.
- rst_n_i pulled low with 2 entries buffered -> valid_o=0 the next cycle and the first post-reset pair has pc_o=RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the instruction fetch front end.
//   IMEM_AW       : instruction memory doubleword address width
//   NOP_INST      : encoding used to fill an unused second slot
//   fetch_entry_t : one fetched instruction pair as held in the fetch buffer
//   fetch_state_t : fetch controller states
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int          IMEM_AW  = 10;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic [1:0]  vld;
    } fetch_entry_t;

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } fetch_state_t;

    // Sequential successor of a fetch PC: realign to the doubleword, step one.
    function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
        return (pc & ~32'h7) + 32'd8;
    endfunction

    // Split a returned doubleword into program-ordered slots. A PC in the
    // upper word only has one useful instruction, so slot 1 becomes a NOP.
    function automatic fetch_entry_t make_entry(input logic [31:0] pc,
                                                input logic [63:0] data);
        fetch_entry_t e;
        e.pc = pc;
        if (pc[2]) begin
            e.inst0 = data[63:32];
            e.inst1 = NOP_INST;
            e.vld   = 2'b01;
        end else begin
            e.inst0 = data[31:0];
            e.inst1 = data[63:32];
            e.vld   = 2'b11;
        end
        return e;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Bundles every non-clock signal of the fetch controller.
//   backend control : redirect_i, redirect_pc_i, halt_i
//   imem port       : addr_o (doubleword address), data_i (64-bit, 1-cycle latency)
//   pair output     : valid_o/ready_i handshake, pc_o, inst_0_o, inst_1_o, slot_vld_o
// modport master : the fetch controller side
// modport slave  : the environment (backend + instruction memory)
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
    import core_pkg::*;

    logic               redirect_i;
    logic [31:0]        redirect_pc_i;
    logic               halt_i;
    logic [IMEM_AW-1:0] addr_o;
    logic [63:0]        data_i;
    logic               valid_o;
    logic               ready_i;
    logic [31:0]        pc_o;
    logic [31:0]        inst_0_o;
    logic [31:0]        inst_1_o;
    logic [1:0]         slot_vld_o;

    modport master (
        input  redirect_i, redirect_pc_i, halt_i, data_i, ready_i,
        output addr_o, valid_o, pc_o, inst_0_o, inst_1_o, slot_vld_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, halt_i, data_i, ready_i,
        input  addr_o, valid_o, pc_o, inst_0_o, inst_1_o, slot_vld_o
    );

endinterface

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Two-entry FIFO of fetched instruction pairs. The head entry is a register,
// so everything downstream sees only flopped values.
//   clock_i, rst_n_i : clock, synchronous active-low reset
//   flush_i          : drop all entries (wins over push/pop)
//   push_i           : push_entry_i enters the FIFO
//   pop_i            : head is consumed this cycle
//   head_o, valid_o  : head entry and "not empty"
//   count_o          : occupancy 0..2
// Push and pop may coincide at any occupancy.
// -----------------------------------------------------------------------------
module fetch_buf
    import core_pkg::*;
(
    input  logic         clock_i,
    input  logic         rst_n_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop, do_push;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can
        // leave one unassigned and infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = push_entry_i;
                    else                 tail_d = push_entry_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the newcomer lands behind
                    // whatever survives the pop.
                    if (count_q == 2'd1) begin
                        head_d = push_entry_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_entry_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        // NOTE: state updates use non-blocking assignments so all flops
        // sample their pre-edge inputs regardless of process order.
        if (!rst_n_i) begin
            // NOTE: the storage is reset too, not just the count, because the
            // head drives pc_o/inst_*_o directly and must read zero in reset.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch controller: issues doubleword reads to a 1-cycle-latency
// instruction memory, splits each return into an instruction pair and queues
// it in a 2-entry buffer for the decode stage.
//   clock_i  : rising-edge clock
//   rst_n_i  : synchronous active-low reset
//   bus      : fetch_ctrl_if.master (redirect/halt, imem port, pair output)
//   RESET_PC : first fetch PC after reset
// addr_o is the current fetch PC[12:3]; it only moves when a fetch issues or
// on redirect, so it holds steady while stalled.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clock_i,
    input  logic         rst_n_i,
    fetch_ctrl_if.master bus
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;

    logic         issue;
    logic         push;
    logic         pop;
    logic         buf_valid;
    logic [1:0]   buf_count;
    logic [2:0]   committed;
    fetch_entry_t head;

    assign pop = buf_valid && bus.ready_i;

    // A return arriving in a redirect cycle belongs to the old path.
    assign push = inflight_q && !bus.redirect_i;

    // Slots already spoken for once this cycle's pop is taken into account.
    // Counting the pop is what lets a full-rate stream issue every cycle.
    assign committed = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        issue         = 1'b0;

        if (bus.redirect_i) begin
            // No fetch this cycle: the target goes onto addr_o next cycle and
            // issues from there with an empty pipeline.
            state_d = ST_RUN;
            pc_d    = {bus.redirect_pc_i[31:2], 2'b00};
        end else begin
            case (state_q)
                ST_BOOT: begin
                    issue   = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    issue = !bus.halt_i && (committed < 3'd2);
                end
                default: state_d = ST_BOOT;
            endcase
        end

        if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = seq_next_pc(pc_q);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC & ~32'h3;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_buf u_buf (
        .clock_i      (clock_i),
        .rst_n_i      (rst_n_i),
        .flush_i      (bus.redirect_i),
        .push_i       (push),
        .push_entry_i (make_entry(inflight_pc_q, bus.data_i)),
        .pop_i        (pop),
        .head_o       (head),
        .valid_o      (buf_valid),
        .count_o      (buf_count)
    );

    assign bus.addr_o     = pc_q[12:3];
    assign bus.valid_o    = buf_valid;
    assign bus.pc_o       = head.pc;
    assign bus.inst_0_o   = head.inst0;
    assign bus.inst_1_o   = head.inst1;
    assign bus.slot_vld_o = head.vld;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl with a behavioural 1-cycle instruction memory.
// Memory word contents encode their address: lower word 0xA000_0000|addr,
// upper word 0xB000_0000|addr, so every expected slot is derived from the PC.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
    import core_pkg::*;

    logic clock_i;
    logic rst_n_i;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clock_i (clock_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    int x0;
    logic [31:0] last_xfer_pc = '0;

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    function automatic logic [31:0] lo_word(input logic [9:0] a);
        return 32'hA000_0000 | {22'd0, a};
    endfunction

    function automatic logic [31:0] hi_word(input logic [9:0] a);
        return 32'hB000_0000 | {22'd0, a};
    endfunction

    // Synchronous-read instruction memory: address in cycle T, data in T+1.
    always @(posedge clock_i)
        bus.data_i <= {hi_word(bus.addr_o), lo_word(bus.addr_o)};

    // Transfer monitor.
    always @(posedge clock_i) begin
        if (rst_n_i && bus.valid_o && bus.ready_i) begin
            xfer_cnt     <= xfer_cnt + 1;
            last_xfer_pc <= bus.pc_o;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 64'(bus.valid_o), 64'd0);
    endtask

    task automatic check_addr(input string tag, input logic [9:0] a);
        check({tag, ".addr"}, 64'(bus.addr_o), 64'(a));
    endtask

    task automatic check_pair(input string tag, input logic [31:0] pc);
        logic [9:0]  a;
        logic [31:0] e0, e1;
        logic [1:0]  ev;
        a = pc[12:3];
        if (pc[2]) begin
            e0 = hi_word(a); e1 = NOP_INST; ev = 2'b01;
        end else begin
            e0 = lo_word(a); e1 = hi_word(a); ev = 2'b11;
        end
        check({tag, ".valid"}, 64'(bus.valid_o),    64'd1);
        check({tag, ".pc"},    64'(bus.pc_o),       64'(pc));
        check({tag, ".inst0"}, 64'(bus.inst_0_o),   64'(e0));
        check({tag, ".inst1"}, 64'(bus.inst_1_o),   64'(e1));
        check({tag, ".slot"},  64'(bus.slot_vld_o), 64'(ev));
    endtask

    initial begin
        rst_n_i           = 1'b0;
        bus.ready_i       = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.halt_i        = 1'b0;

        // Reset values.
        tick();
        tick();
        check("rst.valid", 64'(bus.valid_o),    64'd0);
        check("rst.slot",  64'(bus.slot_vld_o), 64'd0);
        check("rst.pc",    64'(bus.pc_o),       64'd0);
        check("rst.inst0", 64'(bus.inst_0_o),   64'd0);
        check("rst.inst1", 64'(bus.inst_1_o),   64'd0);
        check_addr("rst", 10'h000);

        // Release: BOOT issues 0, first pair two edges later, then one per cycle.
        rst_n_i = 1'b1;
        tick();
        check_idle("boot");
        check_addr("boot", 10'h001);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_pair($sformatf("stream%0d", k), 32'(8 * k));
        end

        // Redirect to 0x104 while a transfer and a return happen together.
        x0 = xfer_cnt;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0104;
        tick();
        bus.redirect_i = 1'b0;
        check_idle("redir1.n1");
        check_addr("redir1.n1", 10'h020);
        tick();
        check_idle("redir1.n2");
        check("redir1.xfers",   64'(xfer_cnt - x0), 64'd1);
        check("redir1.last_pc", 64'(last_xfer_pc),  64'h28);
        tick();
        check_pair("redir1.tgt", 32'h0000_0104);
        tick();
        check_pair("redir1.next", 32'h0000_0108);

        // Downstream stall for 5 cycles: FIFO fills, addr holds.
        bus.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_pair($sformatf("stall%0d", i), 32'h0000_0108);
            check_addr($sformatf("stall%0d", i), 10'h023);
            check($sformatf("stall%0d.count", i), 64'(dut.buf_count), 64'd2);
        end
        bus.ready_i = 1'b1;
        tick();
        check_pair("unstall0", 32'h0000_0110);
        tick();
        check_pair("unstall1", 32'h0000_0118);
        tick();
        check_pair("unstall2", 32'h0000_0120);

        // Halt: in-flight data still lands, FIFO drains, PC held.
        bus.halt_i = 1'b1;
        tick();
        check_pair("halt.drain", 32'h0000_0128);
        tick();
        check_idle("halt.empty1");
        check_addr("halt.empty1", 10'h026);
        tick();
        check_idle("halt.empty2");
        check_addr("halt.empty2", 10'h026);
        bus.halt_i = 1'b0;
        tick();
        check_idle("resume.n1");
        tick();
        check_pair("resume.first", 32'h0000_0130);
        tick();
        check_pair("resume.second", 32'h0000_0138);

        // Redirect to 0x1FF8 with a coincident transfer and return; addr wraps.
        x0 = xfer_cnt;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_1FF8;
        tick();
        bus.redirect_i = 1'b0;
        check_idle("wrap.n1");
        check_addr("wrap.n1", 10'h3FF);
        tick();
        check_idle("wrap.n2");
        check_addr("wrap.n2", 10'h000);
        check("wrap.xfers",   64'(xfer_cnt - x0), 64'd1);
        check("wrap.last_pc", 64'(last_xfer_pc),  64'h138);
        tick();
        check_pair("wrap.tgt", 32'h0000_1FF8);
        tick();
        check_pair("wrap.next", 32'h0000_2000);

        // Reset with two entries buffered.
        bus.ready_i = 1'b0;
        tick();
        check_pair("prerst", 32'h0000_2000);
        check("prerst.count", 64'(dut.buf_count), 64'd2);
        rst_n_i = 1'b0;
        tick();
        check_idle("midrst");
        check("midrst.slot", 64'(bus.slot_vld_o), 64'd0);
        check("midrst.pc",   64'(bus.pc_o),       64'd0);
        check_addr("midrst", 10'h000);
        rst_n_i     = 1'b1;
        bus.ready_i = 1'b1;
        tick();
        check_idle("postrst.boot");
        tick();
        check_pair("postrst.first", 32'h0000_0000);
        tick();
        check_pair("postrst.second", 32'h0000_0008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
